// File: rtl/uart_rx_engine.sv
// UART receive engine: 16x oversampled start/data/parity/stop framing with
// 7/8 data bits, optional odd/even parity and registered character/status flags.
module uart_rx_engine (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       rx_sample_pulse,
  input  logic       UART_RX,
  input  logic       data_bits,
  input  logic       parity_en,
  input  logic       parity_odd0_even1,
  input  logic       rx_data_reg_rd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, rx_s_q;
  logic [1:0] primed_q;
  logic       prev_rx_q, prev_rx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       cfg_8bit_q, cfg_8bit_d;
  logic       cfg_par_q, cfg_par_d;
  logic       cfg_even_q, cfg_even_d;
  logic       perr_pend_q, perr_pend_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_ready_q, rx_ready_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       overflow_q, overflow_d;
  logic       wrap_s, load_s, start_edge_s;
  logic [7:0] frame_s;

  function automatic logic parity_error(input logic [7:0] data, input logic par_bit,
                                        input logic even);
    logic x;
    x = (^data) ^ par_bit;
    return even ? x : ~x;
  endfunction

  // Line synchronizer; primed_q marks when rx_s_q reflects the real line after reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      primed_q <= 2'b00;
    end else begin
      sync1_q  <= UART_RX;
      rx_s_q   <= sync1_q;
      primed_q <= {primed_q[0], 1'b1};
    end
  end

  // 7-bit frames land in shift_q[7:1] after seven LSB-first shifts.
  assign frame_s      = cfg_8bit_q ? shift_q : {1'b0, shift_q[7:1]};
  assign wrap_s       = rx_sample_pulse && (cnt_q == 4'd15);
  assign start_edge_s = rx_sample_pulse && primed_q[1] && prev_rx_q && !rx_s_q;

  // Frame FSM next-state and receive datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    cfg_8bit_d  = cfg_8bit_q;
    cfg_par_d   = cfg_par_q;
    cfg_even_d  = cfg_even_q;
    perr_pend_d = perr_pend_q;
    prev_rx_d   = prev_rx_q;
    load_s      = 1'b0;

    // prev stays 0 until the synchronizer holds real line data, so a line low from reset never looks like an edge
    if (rx_sample_pulse) begin
      prev_rx_d = primed_q[1] ? rx_s_q : 1'b0;
    end else begin
      prev_rx_d = prev_rx_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d     = 4'd0;
        bit_cnt_d = 3'd0;
        if (start_edge_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (rx_sample_pulse) begin
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (!rx_s_q) begin
              cfg_8bit_d  = data_bits;
              cfg_par_d   = parity_en;
              cfg_even_d  = parity_odd0_even1;
              bit_cnt_d   = 3'd0;
              shift_d     = 8'h00;
              perr_pend_d = 1'b0;
              state_d     = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DATA: begin
        if (rx_sample_pulse) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (wrap_s) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_cnt_q == (cfg_8bit_q ? 3'd7 : 3'd6)) begin
            bit_cnt_d = 3'd0;
            state_d   = cfg_par_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      PARITY: begin
        if (rx_sample_pulse) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (wrap_s) begin
          perr_pend_d = parity_error(frame_s, rx_s_q, cfg_even_q);
          state_d     = STOP;
        end else begin
          perr_pend_d = perr_pend_q;
        end
      end
      STOP: begin
        if (rx_sample_pulse) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (wrap_s) begin
          load_s  = 1'b1;
          state_d = IDLE;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output register next-state: a load always wins over a coincident read.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_ready_d    = rx_ready_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    if (load_s) begin
      rx_data_d     = frame_s;
      rx_ready_d    = 1'b1;
      parity_err_d  = perr_pend_q;
      framing_err_d = !rx_s_q;
      if (rx_data_reg_rd) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q | rx_ready_q;
      end
    end else if (rx_data_reg_rd) begin
      rx_ready_d    = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      rx_ready_d = rx_ready_q;
    end
  end

  // State and output registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      prev_rx_q     <= 1'b0;
      cnt_q         <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      cfg_8bit_q    <= 1'b0;
      cfg_par_q     <= 1'b0;
      cfg_even_q    <= 1'b0;
      perr_pend_q   <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_rx_q     <= prev_rx_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      cfg_8bit_q    <= cfg_8bit_d;
      cfg_par_q     <= cfg_par_d;
      cfg_even_q    <= cfg_even_d;
      perr_pend_q   <= perr_pend_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Randomized and directed bench for uart_rx_engine against a frame-level
// reference model of the character and status registers.
module tb_uart_rx_engine;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       rx_sample_pulse;
  logic       UART_RX;
  logic       data_bits;
  logic       parity_en;
  logic       parity_odd0_even1;
  logic       rx_data_reg_rd;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // reference model of the visible registers
  logic [7:0] m_data;
  logic       m_ready, m_perr, m_ferr, m_ovf;

  uart_rx_engine dut (
    .PCLK              (PCLK),
    .PRESET            (PRESET),
    .rx_sample_pulse   (rx_sample_pulse),
    .UART_RX           (UART_RX),
    .data_bits         (data_bits),
    .parity_en         (parity_en),
    .parity_odd0_even1 (parity_odd0_even1),
    .rx_data_reg_rd    (rx_data_reg_rd),
    .rx_data           (rx_data),
    .rx_ready          (rx_ready),
    .parity_err        (parity_err),
    .framing_err       (framing_err),
    .overflow          (overflow)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".data"},  rx_data,             m_data);
    check_val({tag, ".ready"}, {7'd0, rx_ready},    {7'd0, m_ready});
    check_val({tag, ".perr"},  {7'd0, parity_err},  {7'd0, m_perr});
    check_val({tag, ".ferr"},  {7'd0, framing_err}, {7'd0, m_ferr});
    check_val({tag, ".ovf"},   {7'd0, overflow},    {7'd0, m_ovf});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_perr  = 1'b0;
    m_ferr  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    PRESET = 1'b1;
    tick(2);
    model_reset();
    check_outputs(tag);
    PRESET = 1'b0;
  endtask

  task automatic do_read(input string tag);
    rx_data_reg_rd = 1'b1;
    tick(1);
    rx_data_reg_rd = 1'b0;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_perr  = 1'b0;
    m_ferr  = 1'b0;
    check_outputs(tag);
  endtask

  // Send one frame; the stop bit is sampled 11 cycles into its bit time
  // (2 sync + 1 edge detect + 8 to start midpoint, then whole bits of 16).
  task automatic send_frame(input string tag, input logic [7:0] d, input logic eight,
                            input logic pen, input logic even, input logic par_bit,
                            input logic stop, input logic rd_at_load, input logic scramble);
    logic [7:0] dm;
    logic       exp_perr;
    int         nd;
    nd = eight ? 8 : 7;
    dm = eight ? d : {1'b0, d[6:0]};
    if (pen) begin
      if (even) exp_perr = ((^dm) ^ par_bit) != 1'b0;
      else      exp_perr = ((^dm) ^ par_bit) == 1'b0;
    end else begin
      exp_perr = 1'b0;
    end
    data_bits = eight;
    parity_en = pen;
    parity_odd0_even1 = even;
    UART_RX = 1'b0;
    tick(16);
    for (int i = 0; i < nd; i++) begin
      UART_RX = dm[i];
      if (scramble && i == 1) begin
        data_bits         = 1'($urandom);
        parity_en         = 1'($urandom);
        parity_odd0_even1 = 1'($urandom);
      end
      tick(16);
    end
    if (pen) begin
      UART_RX = par_bit;
      tick(16);
    end
    UART_RX = stop;
    tick(10);
    check_val({tag, ".pre_ready"}, {7'd0, rx_ready}, {7'd0, m_ready});
    check_val({tag, ".pre_data"}, rx_data, m_data);
    rx_data_reg_rd = rd_at_load;
    tick(1);
    rx_data_reg_rd = 1'b0;
    if (rd_at_load) m_ovf = 1'b0;
    else if (m_ready) m_ovf = 1'b1;
    m_ready = 1'b1;
    m_data  = dm;
    m_perr  = exp_perr;
    m_ferr  = ~stop;
    check_outputs(tag);
    tick(5);
    UART_RX = 1'b1;
    tick(6);
  endtask

  initial begin
    logic [7:0] d;
    logic       e8, pen, ev, pb, stp, rdl;
    PRESET = 1'b1;
    rx_sample_pulse = 1'b1;
    UART_RX = 1'b0;
    data_bits = 1'b1;
    parity_en = 1'b0;
    parity_odd0_even1 = 1'b0;
    rx_data_reg_rd = 1'b0;
    tick(1);
    do_reset("reset");

    // line held low out of reset must not start a frame
    tick(40);
    check_outputs("low_from_reset");
    UART_RX = 1'b1;
    tick(10);
    check_outputs("low_release");

    send_frame("8N1_A5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read("rd_A5");
    send_frame("7E1_41_bad", 8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_read("rd_41a");
    send_frame("7E1_41_ok", 8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read("rd_41b");
    send_frame("8O1_00_ferr", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read("rd_00");

    // false start: low for 4 sample pulses then high
    UART_RX = 1'b0;
    tick(4);
    UART_RX = 1'b1;
    tick(40);
    check_outputs("false_start");
    send_frame("8N1_3C", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // overflow and read/load collision
    send_frame("ovf_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame("ovf_22", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read("ovf_rd");
    send_frame("coll_33", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("ovf_44", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame("coll_55", 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // reset in the middle of DATA with an unread character held
    UART_RX = 1'b0;
    tick(16);
    UART_RX = 1'b1;
    tick(16);
    UART_RX = 1'b0;
    tick(20);
    UART_RX = 1'b1;
    do_reset("mid_reset");
    tick(200);
    check_outputs("post_reset_idle");
    send_frame("8N1_5A", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read("rd_5A");

    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      e8  = 1'($urandom);
      pen = 1'($urandom);
      ev  = 1'($urandom);
      pb  = 1'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      rdl = ($urandom_range(0, 3) == 0);
      send_frame("rand", d, e8, pen, ev, pb, stp, rdl, 1'b1);
      if ($urandom_range(0, 1) == 1) do_read("rand_rd");
      tick($urandom_range(0, 30));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
